puf_race_controller: RTL

PUF_RACE_CONTROLLER -- requirements
Module: puf_race_controller

---
 rtl/puf_pkg.sv | 18 +
 rtl/race_timer.sv | 31 +++
 rtl/puf_race_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Shared types and default parameter values for the PUF race controller.
// Optional PUF_TIMEOUT_EN adds a per-bit race timeout.
package puf_pkg;

    localparam int RESP_BITS_DEF = 8;
    localparam int SEL_W_DEF     = 4;
    localparam int TIMEOUT_DEF   = 1023;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_RACE,
        S_RECORD,
        S_DONE
    } state_e;

endpackage

// File: rtl/race_timer.sv
// Counts RACE cycles and flags expiry on the TIMEOUT-th enabled cycle.
// Only instantiated when PUF_TIMEOUT_EN is defined.
module race_timer
    import puf_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/puf_race_controller.sv
// Ring-oscillator race PUF sequencer: one arbiter race per response bit.
// Define PUF_TIMEOUT_EN to bound each race to TIMEOUT cycles and flag err.
module puf_race_controller
    import puf_pkg::*;
#(
    parameter int RESP_BITS = RESP_BITS_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEL_W-1:0]     challenge,
    output logic [SEL_W-1:0]     ro_sel_a,
    output logic [SEL_W-1:0]     ro_sel_b,
    output logic                 ro_clr,
    output logic                 ro_en,
    output logic                 arb_rst,
    input  logic                 arb_done,
    input  logic                 arb_winner,
    output logic                 busy,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 err
);

    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(RESP_BITS - 1);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     chal_q, chal_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic                 win_q, win_d;
    logic [SEL_W-1:0]     sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic                 clr_q, en_q, arb_rst_q, busy_q, valid_q;
    logic                 race_end, win_bit;

`ifdef PUF_TIMEOUT_EN
    logic tmo;
    logic err_q;

    race_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q != S_RACE),
        .en_i      (state_q == S_RACE),
        .expired_o (tmo)
    );

    // A completed race wins over a coincident expiry; a timeout records 0.
    assign race_end = arb_done | tmo;
    assign win_bit  = arb_done & arb_winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            err_q <= 1'b0;
        end else if (state_q == S_RACE && !arb_done && tmo) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign race_end = arb_done;
    assign win_bit  = arb_winner;
    assign err      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        chal_d  = chal_q;
        idx_d   = idx_q;
        resp_d  = resp_q;
        win_d   = win_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    idx_d   = '0;
                    resp_d  = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_RACE;
            S_RACE: begin
                if (race_end) begin
                    win_d   = win_bit;
                    state_d = S_RECORD;
                end
            end
            S_RECORD: begin
                resp_d[idx_q] = win_q;
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_DONE: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Pair i races oscillators base+2i and base+2i+1, wrapping freely.
        sel_a_d = chal_d + SEL_W'({idx_d, 1'b0});
        sel_b_d = sel_a_d + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            chal_q    <= '0;
            idx_q     <= '0;
            resp_q    <= '0;
            win_q     <= 1'b0;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            clr_q     <= 1'b0;
            en_q      <= 1'b0;
            arb_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            chal_q    <= chal_d;
            idx_q     <= idx_d;
            resp_q    <= resp_d;
            win_q     <= win_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            clr_q     <= (state_d == S_CLEAR);
            en_q      <= (state_d == S_RACE);
            arb_rst_q <= (state_d != S_RACE);
            busy_q    <= (state_d != S_IDLE);
            valid_q   <= (state_d == S_DONE);
        end
    end

    assign ro_sel_a   = sel_a_q;
    assign ro_sel_b   = sel_b_q;
    assign ro_clr     = clr_q;
    assign ro_en      = en_q;
    assign arb_rst    = arb_rst_q;
    assign busy       = busy_q;
    assign resp       = resp_q;
    assign resp_valid = valid_q;

endmodule
